// File: rtl/seq_pkg.sv
// Shared definitions for the sequence player: symbol geometry, FSM states
// and the symbol-select helper.
package seq_pkg;

  localparam int SYM_W = 4;
  localparam int N_SYM = 16;
  localparam int SEQ_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [SYM_W-1:0] sym(input logic [SEQ_W-1:0] s,
                                           input logic [3:0]       idx);
    return s[{idx, 2'b00} +: SYM_W];
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the ON and OFF phases; holds at zero.
module seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         R,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge R) begin
    if (!R)               cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_player.sv
// Plays a latched 64-bit symbol sequence on the LEDs, ON_CYC lit / OFF_CYC blank
// per symbol. Define SEQ_PLAYER_ABORT_EN to add the abort input.
module seq_player
  import seq_pkg::*;
#(
  parameter int ON_CYC  = 50_000_000,
  parameter int OFF_CYC = 25_000_000
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [4:0]       len,
  input  logic [SEQ_W-1:0] seq,
`ifdef SEQ_PLAYER_ABORT_EN
  input  logic             abort,
`endif
  output logic [SYM_W-1:0] leds,
  output logic             busy,
  output logic             done
);

  localparam int MAXC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] ON_TOP  = TW'(ON_CYC - 1);
  localparam logic [TW-1:0] OFF_TOP = TW'(OFF_CYC - 1);

  state_t             state, state_n;
  logic [3:0]         idx, idx_n;
  logic [SEQ_W-1:0]   seq_sh;
  logic [4:0]         len_sh, len_c;
  logic               cap;
  logic               t_load, t_zero;
  logic [TW-1:0]      t_val;
  logic [SYM_W-1:0]   leds_n;
  logic               busy_n, done_n;
  logic [SEQ_W-1:0]   src;

  seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .R        (R),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  assign len_c = (len > 5'(N_SYM)) ? 5'(N_SYM) : len;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cap     = 1'b0;
    t_load  = 1'b0;
    t_val   = ON_TOP;
    unique case (state)
      IDLE: if (start) begin
        cap = 1'b1;
        if (len_c == 5'd0) state_n = DONE;
        else begin
          state_n = ON;
          idx_n   = '0;
          t_load  = 1'b1;
        end
      end
      ON: if (t_zero) begin
        state_n = OFF;
        t_load  = 1'b1;
        t_val   = OFF_TOP;
      end
      OFF: if (t_zero) begin
        if (idx == 4'(len_sh - 5'd1)) state_n = DONE;
        else begin
          state_n = ON;
          idx_n   = (idx != 4'd15) ? idx + 4'd1 : idx;
          t_load  = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef SEQ_PLAYER_ABORT_EN
    if (abort && (state == ON || state == OFF)) begin
      state_n = DONE;
      idx_n   = idx;
      t_load  = 1'b0;
    end
`endif
    // Outputs are registered from next-state, so the capture cycle reads seq directly.
    src    = cap ? seq : seq_sh;
    leds_n = (state_n == ON) ? sym(src, idx_n) : '0;
    busy_n = (state_n == ON) || (state_n == OFF);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state  <= IDLE;
      idx    <= '0;
      seq_sh <= '0;
      len_sh <= '0;
      leds   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (cap) begin
        seq_sh <= seq;
        len_sh <= len_c;
      end
      leds <= leds_n;
      busy <= busy_n;
      done <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Directed self-checking bench for seq_player with ON_CYC=3, OFF_CYC=2.
module tb_seq_player;

  localparam int ONC  = 3;
  localparam int OFFC = 2;

  logic        clk = 1'b0;
  logic        R;
  logic        start;
  logic [4:0]  len;
  logic [63:0] seq;
  logic        abort;
  logic [3:0]  leds;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  seq_player #(.ON_CYC(ONC), .OFF_CYC(OFFC)) dut (
    .clk   (clk),
    .R     (R),
    .start (start),
    .len   (len),
    .seq   (seq),
`ifdef SEQ_PLAYER_ABORT_EN
    .abort (abort),
`endif
    .leds  (leds),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a playback and checks every cycle through the done pulse.
  // With disturb set, start is re-pulsed and seq/len changed mid-play.
  task automatic play_check(input string tag, input logic [63:0] s, input logic [4:0] l,
                            input int n, input bit disturb);
    logic [63:0] sv;
    logic [3:0]  e;
    int          cyc;
    sv    = s;
    seq   = s;
    len   = l;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < ONC + OFFC; c++) begin
        cyc = k * (ONC + OFFC) + c + 1;
        if (disturb && cyc == 7) begin
          start = 1'b1;
          seq   = ~s;
          len   = 5'd1;
        end
        if (disturb && cyc == 8) start = 1'b0;
        e = (c < ONC) ? sv[4*k +: 4] : 4'h0;
        chk({tag, " leds"}, 32'(leds), 32'(e));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " done"}, 32'(done), 32'd0);
        step();
      end
    end
    chk({tag, " done pulse"}, 32'(done), 32'd1);
    chk({tag, " done busy"},  32'(busy), 32'd0);
    chk({tag, " done leds"},  32'(leds), 32'd0);
    step();
    chk({tag, " done drop"},  32'(done), 32'd0);
    seq = s;
  endtask

  initial begin
    R = 1'b0; start = 1'b0; len = '0; seq = '0; abort = 1'b0;
    #1;
    chk("reset leds", 32'(leds), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    step(); step();
    R = 1'b1;
    step();

    // 1: async reset in the middle of symbol 0
    seq = 64'h8421; len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t1 pre leds", 32'(leds), 32'h1);
    R = 1'b0;
    #1;
    chk("t1 rst leds", 32'(leds), 32'd0);
    chk("t1 rst busy", 32'(busy), 32'd0);
    step(); step();
    R = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1 no done", 32'(done), 32'd0);
      chk("t1 idle leds", 32'(leds), 32'd0);
    end

    // 2: basic four-symbol playback
    play_check("t2", 64'h0000_0000_0000_8421, 5'd4, 4, 1'b0);

    // 3: zero length
    seq = 64'hFFFF; len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3 done", 32'(done), 32'd1);
    chk("t3 busy", 32'(busy), 32'd0);
    chk("t3 leds", 32'(leds), 32'd0);
    step();
    chk("t3 done drop", 32'(done), 32'd0);
    chk("t3 busy idle", 32'(busy), 32'd0);

    // 4: length clamps to 16
    play_check("t4", '1, 5'd20, 16, 1'b0);

    // 5: start/seq/len changes after capture are ignored
    play_check("t5", 64'h0000_0000_0000_8421, 5'd4, 4, 1'b1);

    // start held across done restarts from IDLE
    seq = 64'h7; len = 5'd1; start = 1'b1;
    step();
    for (int i = 0; i < ONC + OFFC; i++) step();
    chk("hold done", 32'(done), 32'd1);
    step();
    chk("hold idle busy", 32'(busy), 32'd0);
    chk("hold idle leds", 32'(leds), 32'd0);
    step();
    start = 1'b0;
    chk("hold restart busy", 32'(busy), 32'd1);
    chk("hold restart leds", 32'(leds), 32'h7);
    for (int i = 0; i < ONC + OFFC + 2; i++) step();
    chk("hold settle", 32'(busy), 32'd0);

`ifdef SEQ_PLAYER_ABORT_EN
    // 6: abort during symbol 1, then replay from symbol 0
    seq = 64'h8421; len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < ONC + OFFC; i++) step();
    chk("t6 sym1", 32'(leds), 32'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6 abort done", 32'(done), 32'd1);
    chk("t6 abort leds", 32'(leds), 32'd0);
    chk("t6 abort busy", 32'(busy), 32'd0);
    step();
    chk("t6 abort drop", 32'(done), 32'd0);
    play_check("t6 replay", 64'h0000_0000_0000_8421, 5'd4, 4, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
